ex_muldiv_unit: RTL

//   Multi-cycle multiply/divide execute unit owning the HI/LO register pair.

---
 rtl/ex_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : ex_muldiv_unit
//  Description : Multi-cycle multiply/divide execute unit owning HI/LO.
//                MULT/MULTU through a latency-MUL_LAT product path, DIV/DIVU
//                by restoring radix-2 division with a final sign-fix cycle,
//                MTHI/MTLO as single-edge register writes.
//  Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int DATA_W  = 32,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              W_start,
    input  logic [2:0]        W_op,
    input  logic [DATA_W-1:0] W_a,
    input  logic [DATA_W-1:0] W_b,
    input  logic              W_flush,
    output logic              W_busy,
    output logic              W_done,
    output logic              W_div_zero,
    output logic [DATA_W-1:0] W_hi,
    output logic [DATA_W-1:0] W_lo
);

    localparam int               CNT_W    = $clog2(DATA_W + MUL_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;
    logic                dz_q, dz_d;
    logic [DATA_W-1:0]   opa_q, opa_d;      // multiplicand
    logic [DATA_W-1:0]   opb_q, opb_d;      // multiplier, or divisor magnitude
    logic                msigned_q, msigned_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quo_q, quo_d;      // dividend shifts out as quotient shifts in
    logic                negq_q, negq_d;
    logic                negr_q, negr_d;
    logic                pzero_q, pzero_d;  // divide-by-zero pending in FIX

    logic [2*DATA_W-1:0] mul_a_ext;
    logic [2*DATA_W-1:0] mul_b_ext;
    logic [2*DATA_W-1:0] mul_prod;
    logic [2*DATA_W-1:0] mul_res;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic                in_signed;
    logic                in_a_neg;
    logic                in_b_neg;

    // Operands are extended to full product width so a single truncated
    // multiply serves both signed and unsigned forms.
    assign mul_a_ext = msigned_q ? {{DATA_W{opa_q[DATA_W-1]}}, opa_q} : {{DATA_W{1'b0}}, opa_q};
    assign mul_b_ext = msigned_q ? {{DATA_W{opb_q[DATA_W-1]}}, opb_q} : {{DATA_W{1'b0}}, opb_q};
    assign mul_prod  = mul_a_ext * mul_b_ext;

    // With a single-cycle latency the product goes straight into HI/LO;
    // otherwise it is taken from the registered stage.
    generate
        if (MUL_LAT == 1) begin : g_mul_direct
            assign mul_res = mul_prod;
        end else begin : g_mul_staged
            assign mul_res = prod_q;
        end
    endgenerate

    assign div_shift = {rem_q, quo_q[DATA_W-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    assign in_signed = ~W_op[0];
    assign in_a_neg  = in_signed & W_a[DATA_W-1];
    assign in_b_neg  = in_signed & W_b[DATA_W-1];

    // Next-state and datapath update for all registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;
        opa_d     = opa_q;
        opb_d     = opb_q;
        msigned_d = msigned_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        pzero_d   = pzero_q;

        case (state_q)
            S_IDLE: begin
                if (W_start && !W_flush) begin
                    case (W_op)
                        OP_MULT, OP_MULTU: begin
                            opa_d     = W_a;
                            opb_d     = W_b;
                            msigned_d = in_signed;
                            cnt_d     = '0;
                            state_d   = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            cnt_d = '0;
                            if (W_b == '0) begin
                                pzero_d = 1'b1;
                                state_d = S_FIX;
                            end else begin
                                pzero_d = 1'b0;
                                quo_d   = in_a_neg ? -W_a : W_a;
                                opb_d   = in_b_neg ? -W_b : W_b;
                                rem_d   = '0;
                                negq_d  = in_a_neg ^ in_b_neg;
                                negr_d  = in_a_neg;
                                state_d = S_DIV;
                            end
                        end
                        OP_MTHI: hi_d = W_a;
                        OP_MTLO: lo_d = W_a;
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                prod_d = mul_prod;
                if (cnt_q == MUL_LAST) begin
                    hi_d    = mul_res[2*DATA_W-1:DATA_W];
                    lo_d    = mul_res[DATA_W-1:0];
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DIV: begin
                // Trial subtract; keep the difference only if it did not borrow.
                if (!div_diff[DATA_W]) begin
                    rem_d = div_diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = div_shift[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                if (cnt_q == DIV_LAST) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FIX: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (pzero_q) begin
                    dz_d = 1'b1;
                end else begin
                    lo_d = negq_q ? -quo_q : quo_q;
                    hi_d = negr_q ? -rem_q : rem_q;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // An abort discards whatever the in-flight op would have committed.
        if (W_flush && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
            dz_d    = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            msigned_q <= 1'b0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            pzero_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            msigned_q <= msigned_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            pzero_q   <= pzero_d;
        end
    end

    assign W_busy     = (state_q != S_IDLE);
    assign W_done     = done_q;
    assign W_div_zero = dz_q;
    assign W_hi       = hi_q;
    assign W_lo       = lo_q;

endmodule
`default_nettype wire
